uart_rx_display_scanner: RTL

Parametrised receive-side display engine: takes the UART receiver's byte/handshake/error outputs and drives an N-digit multiplexed 7-segment display. It replaces the fixed 4-digit byte-to-digit mapping and scan driver in the UART-to-7-segment system. It adds a configurable digit count, a shift-history or byte-count display mode, inter-digit blanking, a clear input, and a saturating error counter. It sits between the UART receiver and the board display pins, in the same clock domain as the receiver.

---
 rtl/uart_rx_display_scanner.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_rx_display_scanner.sv
// Receive-side display engine: turns UART receiver bytes and error flags into an
// N-digit multiplexed, active-low 7-segment display with an errored-byte counter.
module uart_rx_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1024,
    parameter int MODE        = 0
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic [7:0]            Rx_DATA,
    input  logic                  Rx_VALID,
    input  logic                  Rx_PERROR,
    input  logic                  Rx_FERROR,
    input  logic                  Disp_CLR,
    output logic [6:0]            Led_Disp,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [7:0]            Err_CNT
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int GOOD_W = (NUM_DIGITS > 2) ? 4 * (NUM_DIGITS - 2) : 4;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;
    localparam logic [4:0] CODE_P     = 5'd18;

    logic [4:0]        digit [NUM_DIGITS];
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_next;
    logic              valid_q;
    logic              capture;
    logic              is_err;
    logic [4:0]        hi_code;
    logic [4:0]        lo_code;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;

    // Segment set lit for a digit code, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_lit(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'b0111111;
            5'd1:    s = 7'b0000110;
            5'd2:    s = 7'b1011011;
            5'd3:    s = 7'b1001111;
            5'd4:    s = 7'b1100110;
            5'd5:    s = 7'b1101101;
            5'd6:    s = 7'b1111101;
            5'd7:    s = 7'b0000111;
            5'd8:    s = 7'b1111111;
            5'd9:    s = 7'b1101111;
            5'd10:   s = 7'b1110111;
            5'd11:   s = 7'b1111100;
            5'd12:   s = 7'b0111001;
            5'd13:   s = 7'b1011110;
            5'd14:   s = 7'b1111001;
            5'd15:   s = 7'b1110001;
            5'd16:   s = 7'b1000000;
            5'd18:   s = 7'b1110011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Rx_VALID has no ready: a byte is taken on every 0->1 transition of Rx_VALID,
    // with Rx_DATA and the error flags sampled in that same cycle. The edge flop
    // resets high so a level already asserted across reset is ignored.
    always_ff @(posedge Clk) begin
        if (reset) valid_q <= 1'b1;
        else       valid_q <= Rx_VALID;
    end

    assign capture   = Rx_VALID & ~valid_q;
    assign is_err    = Rx_PERROR | Rx_FERROR;
    assign good_next = good_cnt + 1'b1;

    always_comb begin
        hi_code = {1'b0, Rx_DATA[7:4]};
        lo_code = {1'b0, Rx_DATA[3:0]};
        if (is_err) begin
            hi_code = Rx_FERROR ? CODE_DASH : CODE_P;
            lo_code = Rx_FERROR ? CODE_DASH : CODE_P;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset || Disp_CLR) begin
            for (int k = 0; k < NUM_DIGITS; k++) digit[k] <= CODE_BLANK;
            good_cnt <= '0;
            Err_CNT  <= 8'd0;
        end else if (capture) begin
            digit[1] <= hi_code;
            digit[0] <= lo_code;
            if (!is_err) good_cnt <= good_next;
            if (MODE == 0) begin
                for (int k = 2; k < NUM_DIGITS; k++) digit[k] <= digit[k-2];
            end else if (!is_err) begin
                // Upper digits mirror the good-byte counter, one hex nibble each.
                for (int k = 2; k < NUM_DIGITS; k++)
                    digit[k] <= {1'b0, good_next[4*(k-2) +: 4]};
            end
            if (is_err && Err_CNT != 8'hFF) Err_CNT <= Err_CNT + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // First cycle of every slot is dark to avoid ghosting between digits.
    always_ff @(posedge Clk) begin
        if (reset || cnt == '0) begin
            anode    <= '1;
            Led_Disp <= 7'h7F;
        end else begin
            anode    <= ~(ONE_HOT0 << idx);
            Led_Disp <= ~seg_lit(digit[idx]);
        end
    end

endmodule
